// File: rtl/vector_store_sequencer.sv
// Serialises one LANES x LANE_W vector result into a byte-wide memory write port, one lane per cycle.
// Optional feature macro VSTORE_MASK_EN adds a lane_mask port; only the enabled lanes are written.
module vector_store_sequencer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*LANE_W-1:0] data_in,
`ifdef VSTORE_MASK_EN
    input  logic [LANES-1:0]        lane_mask,
`endif
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic                    stall,
    output logic                    done
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*LANE_W-1:0] data_q;
    logic                    capture;

`ifdef VSTORE_MASK_EN
    logic [LANES-1:0] mask_q;
    logic [LANES-1:0] above;
    logic             first_found, next_found;
    logic [IDX_W-1:0] first_idx, next_idx;

    // Returns {found, index of lowest set bit}.
    function automatic logic [IDX_W:0] lowest_set(input logic [LANES-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // Lanes still pending after the one currently being written.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            above[i] = mask_q[i] && (i > int'(idx_q));
        end
    end

    assign {first_found, first_idx} = lowest_set(lane_mask);
    assign {next_found, next_idx}   = lowest_set(above);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
`ifdef VSTORE_MASK_EN
                    state_d = first_found ? WRITE : DONE;
                    idx_d   = first_found ? first_idx : '0;
`else
                    state_d = WRITE;
                    idx_d   = '0;
`endif
                end
            end
            WRITE: begin
`ifdef VSTORE_MASK_EN
                if (next_found) idx_d   = next_idx;
                else            state_d = DONE;
`else
                if (idx_q == IDX_W'(LANES - 1)) state_d = DONE;
                else                            idx_d   = idx_q + 1'b1;
`endif
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
`ifdef VSTORE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                base_q <= base_addr;
`ifdef VSTORE_MASK_EN
                mask_q <= lane_mask;
`endif
            end
        end
    end

    // NOTE: the wide data register is deliberately not reset; it is only observed through mem_we gating.
    always_ff @(posedge clk) begin
        if (capture) data_q <= data_in;
    end

    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_we ? base_q + ADDR_W'(idx_q) : '0;
    assign mem_wdata = mem_we ? data_q[int'(idx_q)*LANE_W +: LANE_W] : '0;
    assign busy      = (state_q != IDLE);
    assign stall     = busy;
    assign done      = (state_q == DONE);

endmodule
